// File: rtl/quiescence_softreg_ctrl_n.sv
// quiescence_softreg_ctrl_n
// Forwards host SoftReg accesses to per-slot quiescence ports. Host writes
// become one-cycle quiescence requests. Host reads become held quiescence
// checks whose answers are collected (bounded by a timeout) and returned
// as one SoftReg response.
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_src_app                       slot ID of this instance (debug only)
//   i_softreg_req_*                 host request: valid / is_write / addr / data
//   o_softreg_resp_*                read response, valid for one cycle
//   i_quiescence_req_*              quiescence request/check aimed at this block
//   o_quiescence_resp_*             this block's quiescence state
//   o_slot_qreq_*                   per-slot request/check (data packed 64b/slot)
//   i_slot_qresp_*                  per-slot response (data packed 64b/slot)
module quiescence_softreg_ctrl_n #(
   parameter int NUM_SLOTS      = 8,
   parameter int ADDR_STRIDE    = 8,
   parameter int FIFO_LOG_DEPTH = 3,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int AMI_APP_BITS   = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [AMI_APP_BITS-1:0]   i_src_app,
   input  logic                      i_softreg_req_valid,
   input  logic                      i_softreg_req_is_write,
   input  logic [31:0]               i_softreg_req_addr,
   input  logic [63:0]               i_softreg_req_data,
   output logic                      o_softreg_resp_valid,
   output logic [63:0]               o_softreg_resp_data,
   input  logic                      i_quiescence_req_valid,
   input  logic                      i_quiescence_req_is_request,
   input  logic [63:0]               i_quiescence_req_data,
   output logic                      o_quiescence_resp_valid,
   output logic [63:0]               o_quiescence_resp_data,
   output logic [NUM_SLOTS-1:0]      o_slot_qreq_valid,
   output logic [NUM_SLOTS-1:0]      o_slot_qreq_is_request,
   output logic [NUM_SLOTS*64-1:0]   o_slot_qreq_data,
   input  logic [NUM_SLOTS-1:0]      i_slot_qresp_valid,
   input  logic [NUM_SLOTS*64-1:0]   i_slot_qresp_data
);

   localparam int DEPTH = 1 << FIFO_LOG_DEPTH;
   localparam int PW    = FIFO_LOG_DEPTH;
   localparam int CW    = FIFO_LOG_DEPTH + 1;
   localparam int SW    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int TW    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [31:0] BCAST_ADDR  = 32'(NUM_SLOTS * ADDR_STRIDE);
   localparam logic [31:0] STATUS_ADDR = 32'((NUM_SLOTS + 1) * ADDR_STRIDE);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
   typedef enum logic [1:0] {K_SLOT, K_BCAST, K_STATUS, K_UNMAPPED} kind_t;

   // ---------------- request FIFO (show-ahead) ----------------
   logic [31:0]    r_fifo_addr [DEPTH];
   logic           r_fifo_wr   [DEPTH];
   logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]  r_count;
   logic           w_full, w_empty, w_enq, w_deq, w_drop;
   state_t         r_state, w_state_next;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   // Full is judged before any same-cycle dequeue, so a full FIFO refuses.
   assign w_enq   = i_softreg_req_valid && !w_full;
   assign w_drop  = i_softreg_req_valid && w_full;
   assign w_deq   = (r_state == S_IDLE) && !w_empty;

   always_ff @(posedge i_clk) begin
      if (w_enq) begin
         r_fifo_addr[r_wr_ptr] <= i_softreg_req_addr;
         r_fifo_wr[r_wr_ptr]   <= i_softreg_req_is_write;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
         if (w_enq && !w_deq)      r_count <= r_count + CW'(1);
         else if (!w_enq && w_deq) r_count <= r_count - CW'(1);
      end
   end

   // ---------------- address decode of the FIFO head ----------------
   logic [31:0]          w_head_addr;
   logic [NUM_SLOTS-1:0] w_slot_hit;
   logic [SW-1:0]        w_dec_slot;
   kind_t                w_dec_kind;

   assign w_head_addr = r_fifo_addr[r_rd_ptr];

   for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_hit
      assign w_slot_hit[gi] = (w_head_addr == 32'(gi * ADDR_STRIDE));
   end

   always_comb begin
      w_dec_slot = '0;
      for (int k = 0; k < NUM_SLOTS; k++)
         if (w_slot_hit[k]) w_dec_slot = SW'(k);
      if (|w_slot_hit)                     w_dec_kind = K_SLOT;
      else if (w_head_addr == BCAST_ADDR)  w_dec_kind = K_BCAST;
      else if (w_head_addr == STATUS_ADDR) w_dec_kind = K_STATUS;
      else                                 w_dec_kind = K_UNMAPPED;
   end

   // ---------------- current transaction datapath ----------------
   logic                 r_cur_is_write;
   kind_t                r_cur_kind;
   logic [SW-1:0]        r_cur_slot;
   logic [NUM_SLOTS-1:0] r_mask, r_bits, w_target;
   logic [63:0]          r_slot_data;
   logic [TW-1:0]        r_timer;
   logic                 r_timeout;
   logic [15:0]          r_timeout_cnt, r_drop_cnt;
   logic                 r_quiesce_pending;
   logic                 w_done, w_timer_last, w_timeout_hit, w_active;

   always_comb begin
      w_target = '0;
      if (r_cur_kind == K_SLOT)       w_target[r_cur_slot] = 1'b1;
      else if (r_cur_kind == K_BCAST) w_target = '1;
   end

   // Completion looks at the registered mask, so a response captured in
   // ISSUE is seen in WAIT (minimum read latency of four cycles).
   assign w_done        = ((r_cur_kind == K_SLOT) || (r_cur_kind == K_BCAST)) &&
                          ((r_mask & w_target) == w_target);
   assign w_timer_last  = (r_timer == TW'(TIMEOUT_CYCLES - 1));
   assign w_timeout_hit = (r_state == S_WAIT) && !w_done && w_timer_last;
   assign w_active      = (r_state == S_ISSUE) || (r_state == S_WAIT);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cur_is_write    <= 1'b0;
         r_cur_kind        <= K_UNMAPPED;
         r_cur_slot        <= '0;
         r_mask            <= '0;
         r_bits            <= '0;
         r_slot_data       <= '0;
         r_timer           <= '0;
         r_timeout         <= 1'b0;
         r_timeout_cnt     <= '0;
         r_drop_cnt        <= '0;
         r_quiesce_pending <= 1'b0;
      end else begin
         if (w_deq) begin
            r_cur_is_write <= r_fifo_wr[r_rd_ptr];
            r_cur_kind     <= w_dec_kind;
            r_cur_slot     <= w_dec_slot;
            r_mask         <= '0;
            r_bits         <= '0;
            r_timer        <= '0;
            r_timeout      <= 1'b0;
         end else if (w_active) begin
            r_timer <= r_timer + TW'(1);
            if (!r_cur_is_write) begin
               for (int j = 0; j < NUM_SLOTS; j++) begin
                  if (w_target[j] && i_slot_qresp_valid[j]) begin
                     r_mask[j] <= 1'b1;
                     r_bits[j] <= i_slot_qresp_data[j*64];
                  end
               end
               if (r_cur_kind == K_SLOT && i_slot_qresp_valid[r_cur_slot])
                  r_slot_data <= i_slot_qresp_data[int'(r_cur_slot)*64 +: 64];
            end
            if (w_timeout_hit) r_timeout <= 1'b1;
         end
         if (w_timeout_hit && r_timeout_cnt != 16'hFFFF)
            r_timeout_cnt <= r_timeout_cnt + 16'd1;
         if (w_drop && r_drop_cnt != 16'hFFFF)
            r_drop_cnt <= r_drop_cnt + 16'd1;
         if (i_quiescence_req_valid && i_quiescence_req_is_request)
            r_quiesce_pending <= 1'b1;
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (!w_empty) w_state_next = S_ISSUE;
         S_ISSUE: begin
            if (r_cur_is_write)                                          w_state_next = S_IDLE;
            else if (r_cur_kind == K_STATUS || r_cur_kind == K_UNMAPPED) w_state_next = S_RESP;
            else                                                         w_state_next = S_WAIT;
         end
         S_WAIT:  if (w_done || w_timer_last) w_state_next = S_RESP;
         S_RESP:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   logic w_pulse, w_hold;

   always_comb begin
      w_pulse                = (r_state == S_ISSUE) && r_cur_is_write;
      w_hold                 = w_active && !r_cur_is_write;
      o_softreg_resp_valid   = (r_state == S_RESP);
      o_softreg_resp_data    = '0;
      o_quiescence_resp_valid = 1'b1;
      o_quiescence_resp_data  = {63'd0, w_empty && (r_state == S_IDLE)};
      if (r_state == S_RESP) begin
         case (r_cur_kind)
            K_SLOT:   o_softreg_resp_data = r_timeout ? '1 : r_slot_data;
            K_BCAST: begin
               o_softreg_resp_data[NUM_SLOTS-1:0] = r_bits;
               o_softreg_resp_data[62] = (&r_mask) && (&r_bits);
               o_softreg_resp_data[63] = r_timeout;
            end
            K_STATUS: begin
               o_softreg_resp_data[15:0]  = r_timeout_cnt;
               o_softreg_resp_data[31:16] = r_drop_cnt;
               o_softreg_resp_data[35:32] = 4'(r_count);
            end
            default:  o_softreg_resp_data = '1;
         endcase
      end
   end

   for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign o_slot_qreq_valid[gi]          = w_target[gi] && (w_pulse || w_hold);
      assign o_slot_qreq_is_request[gi]     = w_target[gi] && w_pulse;
      assign o_slot_qreq_data[gi*64 +: 64]  = {63'd0, w_target[gi] && w_pulse};
   end

   // Debug-only inputs and the sticky pending flag have no consumer here.
   logic w_unused;
   assign w_unused = ^{i_src_app, i_softreg_req_data, i_quiescence_req_data, r_quiesce_pending};

endmodule

// File: tb/tb_quiescence_softreg_ctrl_n.sv
module tb_quiescence_softreg_ctrl_n;
   localparam int NS     = 8;
   localparam int STRIDE = 8;
   localparam int LOGD   = 3;
   localparam int TO     = 16;
   localparam logic [31:0] BCAST_A  = 32'(NS * STRIDE);
   localparam logic [31:0] STATUS_A = 32'((NS + 1) * STRIDE);
   localparam logic [63:0] ONES     = '1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [3:0]        src_app = 4'd3;
   logic              req_valid = 1'b0, req_wr = 1'b0;
   logic [31:0]       req_addr = '0;
   logic [63:0]       req_data = '0;
   logic              resp_valid;
   logic [63:0]       resp_data;
   logic              qreq_valid = 1'b0, qreq_isreq = 1'b0;
   logic [63:0]       qreq_data = '0;
   logic              qresp_valid;
   logic [63:0]       qresp_data;
   logic [NS-1:0]     sq_valid, sq_isreq, sr_valid;
   logic [NS*64-1:0]  sq_data, sr_data;

   logic [NS-1:0]     stall = '0;
   logic [63:0]       slot_val [NS];

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural slot: a non-stalled slot always presents a valid answer.
   always_comb begin
      for (int j = 0; j < NS; j++) begin
         sr_valid[j]          = ~stall[j];
         sr_data[j*64 +: 64]  = slot_val[j];
      end
   end

   quiescence_softreg_ctrl_n #(
      .NUM_SLOTS(NS), .ADDR_STRIDE(STRIDE), .FIFO_LOG_DEPTH(LOGD),
      .TIMEOUT_CYCLES(TO), .AMI_APP_BITS(4)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_src_app(src_app),
      .i_softreg_req_valid(req_valid), .i_softreg_req_is_write(req_wr),
      .i_softreg_req_addr(req_addr), .i_softreg_req_data(req_data),
      .o_softreg_resp_valid(resp_valid), .o_softreg_resp_data(resp_data),
      .i_quiescence_req_valid(qreq_valid), .i_quiescence_req_is_request(qreq_isreq),
      .i_quiescence_req_data(qreq_data),
      .o_quiescence_resp_valid(qresp_valid), .o_quiescence_resp_data(qresp_data),
      .o_slot_qreq_valid(sq_valid), .o_slot_qreq_is_request(sq_isreq),
      .o_slot_qreq_data(sq_data),
      .i_slot_qresp_valid(sr_valid), .i_slot_qresp_data(sr_data)
   );

   typedef struct { logic [63:0] data; int cyc; } resp_t;
   typedef struct { logic [NS-1:0] mask; int cyc; } pulse_t;
   resp_t  exp_q[$];
   pulse_t pulse_q[$];

   int n_checks = 0, n_pass = 0;
   int m_tcnt = 0, m_drop = 0;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference model: decides the outcome of one request from the address
   // map and the current slot behaviour.
   function automatic void model(input logic w, input logic [31:0] a,
                                 output logic hr, output logic [63:0] d, output int lat,
                                 output logic hp, output logic [NS-1:0] pm);
      int   s;
      logic all_ok, any_miss;
      hr = !w; d = '0; lat = 3; hp = 1'b0; pm = '0;
      if (a < BCAST_A && (a % STRIDE) == 0) begin
         s = int'(a / STRIDE);
         if (w) begin hp = 1'b1; pm[s] = 1'b1; end
         else if (stall[s]) begin
            d = ONES; lat = TO + 2;
            if (m_tcnt < 65535) m_tcnt++;
         end else begin d = slot_val[s]; lat = 4; end
      end else if (a == BCAST_A) begin
         if (w) begin hp = 1'b1; pm = '1; end
         else begin
            all_ok = 1'b1; any_miss = 1'b0;
            for (int j = 0; j < NS; j++) begin
               if (stall[j]) begin any_miss = 1'b1; all_ok = 1'b0; end
               else begin
                  d[j] = slot_val[j][0];
                  if (!slot_val[j][0]) all_ok = 1'b0;
               end
            end
            d[62] = all_ok; d[63] = any_miss;
            lat = any_miss ? TO + 2 : 4;
            if (any_miss && m_tcnt < 65535) m_tcnt++;
         end
      end else if (a == STATUS_A) begin
         d = {28'd0, 4'd0, m_drop[15:0], m_tcnt[15:0]};
      end else begin
         d = ONES;
      end
   endfunction

   // Called just after a rising edge; returns the edge number that sampled it.
   task automatic send(input logic w, input logic [31:0] a, output int e);
      req_valid = 1'b1; req_wr = w; req_addr = a; req_data = {$urandom, $urandom};
      @(posedge clk); #1;
      e = cyc;
      req_valid = 1'b0;
   endtask

   task automatic do_txn(input logic w, input logic [31:0] a);
      logic hr, hp; logic [63:0] d; logic [NS-1:0] pm; int lat, e;
      model(w, a, hr, d, lat, hp, pm);
      send(w, a, e);
      // Cycle k after the sampling edge e is observed while cyc == e+k-1.
      if (hr) exp_q.push_back('{d, e + lat - 1});
      if (hp) pulse_q.push_back('{pm, e + 1});
      $display("txn %s addr=%h edge=%0d resp=%0d exp=%h", w ? "WR" : "RD", a, e, hr, d);
   endtask

   task automatic wait_idle(input int budget);
      int  n;
      logic ok;
      n = 0; ok = 1'b0;
      while (!ok && n < budget) begin
         @(negedge clk); n++;
         ok = (exp_q.size() == 0) && (pulse_q.size() == 0) && (qresp_data == 64'd1);
      end
      if (!ok) begin
         n_checks++;
         $display("FAIL wait_idle: still busy after %0d cycles, resp_q=%0d pulse_q=%0d", budget, exp_q.size(), pulse_q.size());
      end
      @(posedge clk); #1;
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an output.
   always @(negedge clk) begin : mon
      resp_t  er;
      pulse_t ep;
      if (rst_n && resp_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_resp: got data %h at cycle %0d, none required", resp_data, cyc);
         end else begin
            er = exp_q.pop_front();
            check64("resp_data", resp_data, er.data);
            if (er.cyc >= 0) check64("resp_cycle", 64'(cyc), 64'(er.cyc));
         end
      end
      if (rst_n && |(sq_valid & sq_isreq)) begin
         if (pulse_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_pulse: got valid %b isreq %b, none required", sq_valid, sq_isreq);
         end else begin
            ep = pulse_q.pop_front();
            check64("pulse_valid", 64'(sq_valid), 64'(ep.mask));
            check64("pulse_isreq", 64'(sq_isreq), 64'(ep.mask));
            check64("pulse_cycle", 64'(cyc), 64'(ep.cyc));
            for (int j = 0; j < NS; j++)
               check64("pulse_data", sq_data[j*64 +: 64], {63'd0, ep.mask[j]});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, s;
      logic w;
      logic [31:0] a;
      for (int j = 0; j < NS; j++) slot_val[j] = 64'd1;

      // Reset values while reset is asserted.
      repeat (3) @(negedge clk);
      check64("rst_resp_valid", 64'(resp_valid), 64'd0);
      check64("rst_slot_valid", 64'(sq_valid), 64'd0);
      check64("rst_qresp_valid", 64'(qresp_valid), 64'd1);
      check64("rst_qresp_data", qresp_data, 64'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Write to slot 3: single pulse in cycle 2, no response.
      do_txn(1'b1, 32'h18); wait_idle(50);
      // Read slot 5 with constant valid answer of 1: response in cycle 4.
      do_txn(1'b0, 32'h28); wait_idle(50);
      // Broadcast read with slot 2 answering 0.
      slot_val[2] = 64'd0;
      do_txn(1'b0, BCAST_A); wait_idle(50);
      slot_val[2] = 64'd1;
      do_txn(1'b0, BCAST_A); wait_idle(50);
      // Timed-out slot read, then STATUS shows one timeout.
      stall[1] = 1'b1;
      do_txn(1'b0, 32'h08); wait_idle(60);
      do_txn(1'b0, STATUS_A); wait_idle(50);
      do_txn(1'b0, 32'h0000_0103); wait_idle(50);

      // Burst of 12 reads at a stalled slot: one dequeued, FIFO fills, rest dropped.
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h08;
      for (int b = 0; b < 12; b++) begin @(posedge clk); #1; end
      req_valid = 1'b0;
      for (int b = 0; b < 1 + (1 << LOGD); b++) begin
         exp_q.push_back('{ONES, -1});
         m_tcnt++;
      end
      m_drop += 12 - (1 + (1 << LOGD));
      $display("txn RD burst x12 addr=00000008");
      check64("quiesce_busy", qresp_data, 64'd0);
      wait_idle(600);
      check64("quiesce_drained", qresp_data, 64'd1);
      do_txn(1'b0, STATUS_A); wait_idle(50);

      // Reset during WAIT abandons the read.
      do_txn(1'b0, 32'h08);
      repeat (4) begin @(posedge clk); #1; end
      check64("wait_hold_valid", 64'(sq_valid), 64'h02);
      rst_n = 1'b0; #1;
      check64("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
      check64("mid_rst_slot_valid", 64'(sq_valid), 64'd0);
      check64("mid_rst_qresp_data", qresp_data, 64'd1);
      exp_q.delete();
      m_tcnt = 0; m_drop = 0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      stall[1] = 1'b0; slot_val[1] = 64'hDEAD_BEEF_0123_4567;
      do_txn(1'b0, 32'h08); wait_idle(50);
      do_txn(1'b0, STATUS_A); wait_idle(50);

      // Randomised traffic, one request in flight at a time.
      for (int t = 0; t < 60; t++) begin
         for (int j = 0; j < NS; j++) begin
            slot_val[j] = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) slot_val[j][0] = 1'b1;
            stall[j] = ($urandom_range(0, 4) == 0);
         end
         k = $urandom_range(0, 7);
         s = $urandom_range(0, NS - 1);
         w = 1'b0;
         case (k)
            0, 1: a = 32'(s * STRIDE);
            2: begin a = 32'(s * STRIDE); w = 1'b1; end
            3: a = BCAST_A;
            4: begin a = BCAST_A; w = 1'b1; end
            5: a = STATUS_A;
            6: begin
               if ($urandom_range(0, 1) == 1) a = 32'(s * STRIDE + $urandom_range(1, STRIDE - 1));
               else a = STATUS_A + 32'(STRIDE * $urandom_range(1, 4));
               w = ($urandom_range(0, 1) == 1);
            end
            default: begin a = STATUS_A; w = 1'b1; end
         endcase
         do_txn(w, a);
         wait_idle(80);
      end

      check64("resp_q_left", 64'(exp_q.size()), 64'd0);
      check64("pulse_q_left", 64'(pulse_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
